// File: rtl/uo_pad_arbiter.sv
// Core-side scheduler for the uo output pad bank: synchronises ui, loops it back when idle,
// and round-robin shares uo among NUM_REQ requesters with a bounded hold time.
//
// state | meaning
// IDLE  | loopback uo = ui_sync, arbitrate pending requests
// GRANT | uo driven from the granted requester's data slice, hold timer running
// TURN  | one-cycle dead time with loopback, requests not sampled
module uo_pad_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 16,
    parameter int MAX_HOLD    = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     io_clock_p2c,
    input  logic                     io_reset_p2c,
    input  logic [WIDTH-1:0]         ui_p2c,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       rel,      // release strobe; "release" is a reserved word
    input  logic [NUM_REQ*WIDTH-1:0] data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         ui_sync,
    output logic [WIDTH-1:0]         uo_c2p,
    output logic                     busy,
    output logic                     timeout_pulse,
    output logic [7:0]               timeout_count
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       g_q, g_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [NUM_REQ-1:0]  gnt_d;
    logic [WIDTH-1:0]    uo_d;
    logic                pulse_d;
    logic [7:0]          tcount_d;
    logic [IW-1:0]       sel;
    logic                found;

    logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]    data_slice [NUM_REQ];

    always_ff @(posedge io_clock_p2c or negedge io_reset_p2c) begin
        if (!io_reset_p2c) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= ui_p2c;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign ui_sync = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign data_slice[i] = data[i*WIDTH +: WIDTH];
    end

    // Search starts just above the last grantee so it ends up with lowest priority.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IW-1:0] cand;
            cand = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        g_d      = g_q;
        hold_d   = hold_q;
        gnt_d    = gnt;
        uo_d     = ui_sync;
        pulse_d  = 1'b0;
        tcount_d = timeout_count;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    g_d        = sel;
                    hold_d     = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                uo_d = data_slice[g_q];
                if (rel[g_q] || !req[g_q]) begin
                    gnt_d   = '0;
                    ptr_d   = g_q;
                    state_d = TURN;
                end else if (hold_q == HOLD_LIM) begin
                    gnt_d   = '0;
                    ptr_d   = g_q;
                    state_d = TURN;
                    pulse_d = 1'b1;
                    if (timeout_count != 8'hFF) tcount_d = timeout_count + 8'd1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            TURN: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge io_clock_p2c or negedge io_reset_p2c) begin
        if (!io_reset_p2c) begin
            state_q       <= IDLE;
            ptr_q         <= IW'(NUM_REQ - 1);
            g_q           <= '0;
            hold_q        <= '0;
            gnt           <= '0;
            uo_c2p        <= '0;
            timeout_pulse <= 1'b0;
            timeout_count <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            g_q           <= g_d;
            hold_q        <= hold_d;
            gnt           <= gnt_d;
            uo_c2p        <= uo_d;
            timeout_pulse <= pulse_d;
            timeout_count <= tcount_d;
        end
    end

    assign busy = (state_q == GRANT);

endmodule
